// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage of the RISC-V core, between execute and
// write-back. Loads and stores run as req/gnt/rvalid transactions on the
// data memory bus. Upstream is stalled until each access completes.
// Non-memory ops reach write-back after one registered cycle.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   ex_valid_i          execute-stage outputs valid
//   ALUop_i             op code (10xxx loads, 110xx stores, others non-memory)
//   MemAddr_i           byte address of the access
//   StoreData_i         store source value
//   WriteDataNum_i      destination register
//   WriteReg_i          register write enable
//   WriteData_i         ALU result for non-memory ops
//   stall_o             upstream must hold its inputs stable
//   dmem_*              data memory bus (word address, byte enables,
//                       lane-replicated store data, gnt/rvalid handshake)
//   wb_valid_o          write-back outputs valid (1-cycle pulse)
//   WriteReg_o          register file write enable
//   WriteDataNum_o      destination register
//   WriteData_o         write-back data
//   misalign_o          1-cycle pulse: misaligned access rejected
//   bus_err_o           1-cycle pulse: access aborted on timeout
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid_i,
   input  logic [4:0]  ALUop_i,
   input  logic [31:0] MemAddr_i,
   input  logic [31:0] StoreData_i,
   input  logic [4:0]  WriteDataNum_i,
   input  logic        WriteReg_i,
   input  logic [31:0] WriteData_i,
   output logic        stall_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        wb_valid_o,
   output logic        WriteReg_o,
   output logic [4:0]  WriteDataNum_o,
   output logic [31:0] WriteData_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   // Last count value in REQ+WAIT before the access is abandoned.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [7:0]  tmo_cnt;
   // Latched op: [3] store, [2] unsigned load, [1:0] size (00 B, 01 H, 10 W)
   logic [3:0]  op_q;
   logic [1:0]  lsb_q;
   logic [4:0]  rd_q;
   logic        wen_q;

   logic        is_mem;
   logic        is_store;
   logic        misaligned;
   logic [3:0]  be_n;
   logic [31:0] wdata_n;
   logic [31:0] rshift;
   logic [31:0] load_val;
   logic        store_done;
   logic        load_done;
   logic        tmo_hit;

   // Op decode and alignment check on the incoming execute-stage op.
   always_comb begin
      is_mem = 1'b0;
      case (ALUop_i)
         5'b10000, 5'b10001, 5'b10010, 5'b10100, 5'b10101,
         5'b11000, 5'b11001, 5'b11010: is_mem = 1'b1;
         default:                      is_mem = 1'b0;
      endcase
      is_store   = ALUop_i[3];
      misaligned = ((ALUop_i[1:0] == 2'b01) && MemAddr_i[0]) ||
                   ((ALUop_i[1:0] == 2'b10) && (MemAddr_i[1:0] != 2'b00));
   end

   // Byte enables and lane-replicated store data by access width.
   always_comb begin
      case (ALUop_i[1:0])
         2'b00: begin
            be_n    = 4'b0001 << MemAddr_i[1:0];
            wdata_n = {4{StoreData_i[7:0]}};
         end
         2'b01: begin
            be_n    = MemAddr_i[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{StoreData_i[15:0]}};
         end
         default: begin
            be_n    = 4'b1111;
            wdata_n = StoreData_i;
         end
      endcase
   end

   // Load lane select: shift the addressed byte/half down to bit 0, then
   // sign- or zero-extend. Words are always aligned, so the shift is 0.
   always_comb begin
      rshift = dmem_rdata_i >> {lsb_q, 3'b000};
      case (op_q[1:0])
         2'b00:   load_val = op_q[2] ? {24'b0, rshift[7:0]}
                                     : {{24{rshift[7]}}, rshift[7:0]};
         2'b01:   load_val = op_q[2] ? {16'b0, rshift[15:0]}
                                     : {{16{rshift[15]}}, rshift[15:0]};
         default: load_val = rshift;
      endcase
   end

   always_comb begin
      store_done = (state == REQ) && dmem_gnt_i && op_q[3];
      load_done  = (state == WAIT) && dmem_rvalid_i;
      tmo_hit    = (tmo_cnt == TMO_LAST);
   end

   // Completion (or abort) releases the stall in the same cycle so that
   // upstream advances on the edge that ends the access.
   always_comb begin
      case (state)
         IDLE:    stall_o = ex_valid_i && is_mem && !misaligned;
         default: stall_o = !(store_done || load_done || tmo_hit);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         tmo_cnt        <= '0;
         op_q           <= '0;
         lsb_q          <= '0;
         rd_q           <= '0;
         wen_q          <= 1'b0;
         wb_valid_o     <= 1'b0;
         WriteReg_o     <= 1'b0;
         WriteDataNum_o <= '0;
         WriteData_o    <= '0;
         misalign_o     <= 1'b0;
         bus_err_o      <= 1'b0;
         dmem_req_o     <= 1'b0;
         dmem_we_o      <= 1'b0;
         dmem_addr_o    <= '0;
         dmem_be_o      <= '0;
         dmem_wdata_o   <= '0;
      end else begin
         wb_valid_o <= 1'b0;
         misalign_o <= 1'b0;
         bus_err_o  <= 1'b0;
         case (state)
            IDLE: begin
               if (ex_valid_i) begin
                  if (!is_mem) begin
                     wb_valid_o     <= 1'b1;
                     WriteReg_o     <= WriteReg_i && (WriteDataNum_i != 5'd0);
                     WriteDataNum_o <= WriteDataNum_i;
                     WriteData_o    <= WriteData_i;
                  end else if (misaligned) begin
                     wb_valid_o     <= 1'b1;
                     misalign_o     <= 1'b1;
                     WriteReg_o     <= 1'b0;
                     WriteDataNum_o <= WriteDataNum_i;
                     WriteData_o    <= '0;
                  end else begin
                     op_q         <= ALUop_i[3:0];
                     lsb_q        <= MemAddr_i[1:0];
                     rd_q         <= WriteDataNum_i;
                     wen_q        <= WriteReg_i;
                     dmem_req_o   <= 1'b1;
                     dmem_we_o    <= is_store;
                     dmem_addr_o  <= {MemAddr_i[31:2], 2'b00};
                     dmem_be_o    <= be_n;
                     dmem_wdata_o <= is_store ? wdata_n : '0;
                     tmo_cnt      <= '0;
                     state        <= REQ;
                  end
               end
            end
            REQ: begin
               if (store_done) begin
                  dmem_req_o     <= 1'b0;
                  wb_valid_o     <= 1'b1;
                  WriteReg_o     <= 1'b0;
                  WriteDataNum_o <= rd_q;
                  WriteData_o    <= '0;
                  state          <= IDLE;
               end else if (tmo_hit) begin
                  dmem_req_o     <= 1'b0;
                  wb_valid_o     <= 1'b1;
                  bus_err_o      <= 1'b1;
                  WriteReg_o     <= 1'b0;
                  WriteDataNum_o <= rd_q;
                  WriteData_o    <= '0;
                  state          <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
                  if (dmem_gnt_i) begin
                     dmem_req_o <= 1'b0;
                     state      <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (load_done) begin
                  wb_valid_o     <= 1'b1;
                  WriteReg_o     <= wen_q && (rd_q != 5'd0);
                  WriteDataNum_o <= rd_q;
                  WriteData_o    <= load_val;
                  state          <= IDLE;
               end else if (tmo_hit) begin
                  wb_valid_o     <= 1'b1;
                  bus_err_o      <= 1'b1;
                  WriteReg_o     <= 1'b0;
                  WriteDataNum_o <= rd_q;
                  WriteData_o    <= '0;
                  state          <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: a driver issues ops and plays the data
// memory, pushing expected write-back results into a scoreboard queue; a
// monitor pops and compares on every wb_valid_o pulse.
module tb_mem_access_unit;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid_i;
   logic [4:0]  ALUop_i;
   logic [31:0] MemAddr_i;
   logic [31:0] StoreData_i;
   logic [4:0]  WriteDataNum_i;
   logic        WriteReg_i;
   logic [31:0] WriteData_i;
   logic        stall_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_gnt_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic        wb_valid_o;
   logic        WriteReg_o;
   logic [4:0]  WriteDataNum_o;
   logic [31:0] WriteData_o;
   logic        misalign_o;
   logic        bus_err_o;

   mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ALUop_i(ALUop_i),
      .MemAddr_i(MemAddr_i), .StoreData_i(StoreData_i),
      .WriteDataNum_i(WriteDataNum_i), .WriteReg_i(WriteReg_i),
      .WriteData_i(WriteData_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
      .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
      .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
      .wb_valid_o(wb_valid_o), .WriteReg_o(WriteReg_o),
      .WriteDataNum_o(WriteDataNum_o), .WriteData_o(WriteData_o),
      .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned checks = 0;
   int unsigned errors = 0;

   typedef struct {
      logic        wreg;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        mis;
      logic        err;
      logic        chk_data;
      int unsigned when;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: access size in bytes (0 = not a memory op), direction, signedness.
   function automatic int unsigned op_bytes(input logic [4:0] op);
      case (op)
         5'b10000, 5'b10100, 5'b11000: return 1;
         5'b10001, 5'b10101, 5'b11001: return 2;
         5'b10010, 5'b11010:           return 4;
         default:                      return 0;
      endcase
   endfunction

   function automatic bit op_store(input logic [4:0] op);
      return (op == 5'b11000) || (op == 5'b11001) || (op == 5'b11010);
   endfunction

   function automatic bit op_signed(input logic [4:0] op);
      return (op == 5'b10000) || (op == 5'b10001);
   endfunction

   function automatic logic [31:0] model_load(input logic [4:0] op, input logic [31:0] addr,
                                              input logic [31:0] word);
      int unsigned nb = op_bytes(op);
      logic [31:0] v  = word >> (8 * (addr % 4));
      if (nb == 1) begin
         v = v & 32'd255;
         if (op_signed(op) && v >= 32'd128) v = v - 32'd256;
      end else if (nb == 2) begin
         v = v & 32'd65535;
         if (op_signed(op) && v >= 32'd32768) v = v - 32'd65536;
      end
      return v;
   endfunction

   function automatic logic [3:0] model_be(input int unsigned nb, input logic [31:0] addr);
      if (nb == 1) return 4'(1 << (addr % 4));
      if (nb == 2) return ((addr % 4) >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] model_wdata(input int unsigned nb, input logic [31:0] d);
      if (nb == 1) return (d & 32'hFF) * 32'h0101_0101;
      if (nb == 2) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   // Monitor: every write-back pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (wb_valid_o) begin
            if (sb.size() == 0) begin
               chk("unexpected_wb", {31'b0, wb_valid_o}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("wb_latency", cyc, e.when);
               chk("WriteReg_o", {31'b0, WriteReg_o}, {31'b0, e.wreg});
               chk("misalign_o", {31'b0, misalign_o}, {31'b0, e.mis});
               chk("bus_err_o", {31'b0, bus_err_o}, {31'b0, e.err});
               if (e.chk_data) begin
                  chk("WriteData_o", WriteData_o, e.data);
                  chk("WriteDataNum_o", {27'b0, WriteDataNum_o}, {27'b0, e.rd});
               end
            end
         end else if (misalign_o || bus_err_o) begin
            chk("stray_pulse", {30'b0, misalign_o, bus_err_o}, 32'd0);
         end
      end
   end

   // Driver: called #1 after a rising edge; returns #1 after the edge that
   // retires the op. g = cycles before gnt, rv = cycles after the gnt cycle
   // before rvalid (0 = the cycle right after gnt).
   task automatic issue(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input logic wen, input logic [31:0] wdata,
                        input int unsigned g, input int unsigned rv, input logic [31:0] rdata);
      int unsigned nb = op_bytes(op);
      bit st = op_store(op);
      bit mis = (nb == 2 && (addr % 2) != 0) || (nb == 4 && (addr % 4) != 0);
      int unsigned done_t, end_t;
      bit complete, in_req;
      ex_valid_i = 1'b1;
      ALUop_i = op; MemAddr_i = addr; StoreData_i = sdata;
      WriteDataNum_i = rd; WriteReg_i = wen; WriteData_i = wdata;
      if (nb == 0 || mis) begin
         // Stray bus responses while idle must be ignored.
         dmem_gnt_i = 1'($urandom % 2);
         dmem_rvalid_i = 1'($urandom % 2);
         dmem_rdata_i = $urandom;
         @(negedge clk);
         chk("stall_idle_op", {31'b0, stall_o}, 32'd0);
         chk("req_idle_op", {31'b0, dmem_req_o}, 32'd0);
         if (nb == 0)
            sb.push_back(exp_t'{wen && (rd != 0), rd, wdata, 1'b0, 1'b0, 1'b1, cyc + 1});
         else
            sb.push_back(exp_t'{1'b0, rd, 32'd0, 1'b1, 1'b0, 1'b0, cyc + 1});
         @(posedge clk); #1;
      end else begin
         dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
         @(negedge clk);
         chk("stall_accept", {31'b0, stall_o}, 32'd1);
         @(posedge clk); #1;
         done_t = st ? g : g + 1 + rv;
         complete = (done_t <= TO - 1);
         end_t = complete ? done_t : TO - 1;
         for (int unsigned t = 0; t <= end_t; t++) begin
            in_req = (t <= g);
            dmem_gnt_i = in_req && (t == g);
            dmem_rvalid_i = (!in_req && t == done_t) || (in_req && !st && ($urandom % 2 == 1));
            dmem_rdata_i = (t == done_t) ? rdata : $urandom;
            @(negedge clk);
            chk("dmem_req_o", {31'b0, dmem_req_o}, {31'b0, in_req});
            if (in_req) begin
               chk("dmem_addr_o", dmem_addr_o, addr & 32'hFFFF_FFFC);
               chk("dmem_we_o", {31'b0, dmem_we_o}, {31'b0, st});
               chk("dmem_be_o", {28'b0, dmem_be_o}, {28'b0, model_be(nb, addr)});
               if (st) chk("dmem_wdata_o", dmem_wdata_o, model_wdata(nb, sdata));
            end
            chk("stall_o", {31'b0, stall_o}, {31'b0, t != end_t});
            if (t == end_t) begin
               if (!complete)
                  sb.push_back(exp_t'{1'b0, rd, 32'd0, 1'b0, 1'b1, 1'b0, cyc + 1});
               else if (st)
                  sb.push_back(exp_t'{1'b0, rd, 32'd0, 1'b0, 1'b0, 1'b0, cyc + 1});
               else
                  sb.push_back(exp_t'{wen && (rd != 0), rd, model_load(op, addr, rdata),
                                      1'b0, 1'b0, 1'b1, cyc + 1});
            end
            @(posedge clk); #1;
         end
      end
      ex_valid_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wb_valid"}, {31'b0, wb_valid_o}, 32'd0);
      chk({tag, "_WriteReg"}, {31'b0, WriteReg_o}, 32'd0);
      chk({tag, "_WriteDataNum"}, {27'b0, WriteDataNum_o}, 32'd0);
      chk({tag, "_WriteData"}, WriteData_o, 32'd0);
      chk({tag, "_pulses"}, {30'b0, misalign_o, bus_err_o}, 32'd0);
      chk({tag, "_req_we"}, {30'b0, dmem_req_o, dmem_we_o}, 32'd0);
      chk({tag, "_addr"}, dmem_addr_o, 32'd0);
      chk({tag, "_be"}, {28'b0, dmem_be_o}, 32'd0);
      chk({tag, "_wdata"}, dmem_wdata_o, 32'd0);
   endtask

   logic [4:0] op_tab [10] = '{5'b10000, 5'b10001, 5'b10010, 5'b10100, 5'b10101,
                               5'b11000, 5'b11001, 5'b11010, 5'b00000, 5'b10011};

   initial begin
      logic [4:0]  op;
      logic [31:0] a;
      int unsigned nb;
      rst = 1'b1; ex_valid_i = 1'b0; ALUop_i = '0; MemAddr_i = '0; StoreData_i = '0;
      WriteDataNum_i = '0; WriteReg_i = 1'b0; WriteData_i = '0;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_stall", {31'b0, stall_o}, 32'd0);
      chk_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed cases
      issue(5'b00000, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234_5678, 0, 0, 32'h0);
      issue(5'b11000, 32'h1003, 32'hAB, 5'd7, 1'b1, 32'hDEAD, 2, 0, 32'h0);
      issue(5'b10000, 32'h2001, 32'h0, 5'd8, 1'b1, 32'h0, 0, 2, 32'h0000_8000);
      issue(5'b10100, 32'h2001, 32'h0, 5'd9, 1'b1, 32'h0, 0, 2, 32'h0000_8000);
      issue(5'b10001, 32'h2002, 32'h0, 5'd10, 1'b1, 32'h0, 1, 0, 32'h8001_0000);
      issue(5'b10010, 32'h3002, 32'h0, 5'd11, 1'b1, 32'h0, 0, 0, 32'h0);
      issue(5'b10010, 32'h3000, 32'h0, 5'd12, 1'b1, 32'h0, 100, 0, 32'h0);
      issue(5'b11010, 32'h3004, 32'hCAFE_F00D, 5'd13, 1'b1, 32'h0, TO - 1, 0, 32'h0);
      issue(5'b10101, 32'h3006, 32'h0, 5'd14, 1'b1, 32'h0, 0, 1, 32'hF00D_1234);

      // Reset while waiting for rvalid, then a stray rvalid in IDLE
      ex_valid_i = 1'b1; ALUop_i = 5'b10010; MemAddr_i = 32'h50; WriteDataNum_i = 5'd3;
      WriteReg_i = 1'b1;
      @(posedge clk); #1;
      dmem_gnt_i = 1'b1;
      @(negedge clk);
      chk("rstwait_req", {31'b0, dmem_req_o}, 32'd1);
      @(posedge clk); #1;
      dmem_gnt_i = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; ex_valid_i = 1'b0;
      @(negedge clk);
      chk("rstwait_req_drop", {31'b0, dmem_req_o}, 32'd0);
      @(posedge clk); #1;
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
      @(posedge clk); #1;
      dmem_rvalid_i = 1'b0;
      @(negedge clk);
      chk_all_zero("stray_rvalid");
      @(posedge clk); #1;
      issue(5'b10010, 32'h40, 32'h0, 5'd0, 1'b1, 32'h0, 0, 0, 32'h1111_2222);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         op = op_tab[$urandom % 10];
         if ($urandom % 8 == 0) op = 5'($urandom);
         a = $urandom;
         nb = op_bytes(op);
         if (nb != 0 && ($urandom % 4 != 0)) a = a - (a % nb);
         issue(op, a, $urandom, 5'($urandom), 1'($urandom), $urandom,
               $urandom % 4, $urandom % 4, $urandom);
         if ($urandom % 4 == 0) begin
            repeat ($urandom % 3 + 1) @(posedge clk);
            #1;
         end
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
